// File: rtl/axi_err_slave_pkg.sv
// Constants shared by the AXI default error responder and the SoC that instantiates it.
// The read data pattern lives here so that firmware and hardware use the same value.
package axi_err_slave_pkg;

  localparam int unsigned IdWidthSlave     = 5;
  localparam logic [63:0] ErrSlaveRespData = 64'hCA11_AB1E_BAD_CAB1E;
  localparam logic [1:0]  RESP_DECERR      = 2'b11;

  // Adds 0, 1 or 2 to the error count, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/axi_err_slave.sv
// Default AXI4 slave: drains writes and answers with DECERR, returns len+1 DECERR read beats,
// and keeps a saturating error count plus the address of the latest failing transaction.
module axi_err_slave
  import axi_err_slave_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = DataWidth'(ErrSlaveRespData)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [31:0]          err_count_o,
  output logic [AddrWidth-1:0] err_addr_o
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DRAIN = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic       R_IDLE  = 1'b0;
  localparam logic       R_DATA  = 1'b1;

  logic [1:0]           w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q;
  logic                 r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q;
  logic [7:0]           r_len_q;
  logic [7:0]           r_beat_q;
  logic [31:0]          err_count_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_ready_o = (w_state_q == W_IDLE);
  assign w_ready_o  = (w_state_q == W_DRAIN);
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_id_o     = w_id_q;
  assign b_resp_o   = RESP_DECERR;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;
  assign b_hs  = b_valid_o & b_ready_i;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DRAIN;
      W_DRAIN: if (w_hs && w_last_i) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) w_id_q <= aw_id_i;
    end
  end

  assign ar_ready_o = (r_state_q == R_IDLE);
  assign r_valid_o  = (r_state_q == R_DATA);
  assign r_id_o     = r_id_q;
  assign r_data_o   = RespData;
  assign r_resp_o   = RESP_DECERR;
  // The beat counter stops at len, so len=255 ends before the 8-bit counter could wrap.
  assign r_last_o   = r_valid_o & (r_beat_q == r_len_q);

  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last_o) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q   <= ar_id_i;
        r_len_q  <= ar_len_i;
        r_beat_q <= '0;
      end else if (r_hs) begin
        r_beat_q <= r_beat_q + 8'd1;
      end
    end
  end

  // When AW and AR land in the same cycle the write address is the one recorded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= sat_add(err_count_q, {1'b0, aw_hs} + {1'b0, ar_hs});
      if (aw_hs)      err_addr_q <= aw_addr_i;
      else if (ar_hs) err_addr_q <= ar_addr_i;
    end
  end

  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_axi_err_slave.sv
// Directed bench for axi_err_slave: write drain/DECERR, reads of len 7 and 255,
// simultaneous AW/AR, counter saturation and reset in the middle of a burst.
module tb_axi_err_slave;

  localparam logic [63:0] RESP_DATA = 64'hCA11_AB1E_BAD_CAB1E;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [4:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [4:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic        r_valid_o, r_ready_i;
  logic [4:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] err_count_o;
  logic [63:0] err_addr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  axi_err_slave dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .aw_valid_i  (aw_valid_i),
    .aw_ready_o  (aw_ready_o),
    .aw_id_i     (aw_id_i),
    .aw_addr_i   (aw_addr_i),
    .w_valid_i   (w_valid_i),
    .w_ready_o   (w_ready_o),
    .w_last_i    (w_last_i),
    .b_valid_o   (b_valid_o),
    .b_ready_i   (b_ready_i),
    .b_id_o      (b_id_o),
    .b_resp_o    (b_resp_o),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .ar_id_i     (ar_id_i),
    .ar_addr_i   (ar_addr_i),
    .ar_len_i    (ar_len_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .err_count_o (err_count_o),
    .err_addr_o  (err_addr_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic awv, input logic wv, input logic wl,
                               input logic br, input logic arv, input logic rr);
    aw_valid_i = awv;
    w_valid_i  = wv;
    w_last_i   = wl;
    b_ready_i  = br;
    ar_valid_i = arv;
    r_ready_i  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int beats;
    int last_count;
    int last_beat;
    int gaps;
    int cyc;

    rst_ni    = 1'b0;
    aw_id_i   = '0;
    aw_addr_i = '0;
    ar_id_i   = '0;
    ar_addr_i = '0;
    ar_len_i  = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #22;
    checkOutput("rst aw_ready", aw_ready_o, 1);
    checkOutput("rst ar_ready", ar_ready_o, 1);
    checkOutput("rst w_ready", w_ready_o, 0);
    checkOutput("rst b_valid", b_valid_o, 0);
    checkOutput("rst r_valid", r_valid_o, 0);
    checkOutput("rst r_last", r_last_o, 0);
    checkOutput("rst b_id", b_id_o, 0);
    checkOutput("rst r_id", r_id_o, 0);
    checkOutput("rst err_count", err_count_o, 0);
    checkOutput("rst err_addr", err_addr_o, 0);
    checkOutput("rst b_resp", b_resp_o, 2'b11);
    checkOutput("rst r_resp", r_resp_o, 2'b11);
    rst_ni = 1'b1;
    tick();

    // single-beat write
    aw_id_i = 5'd5;
    aw_addr_i = 64'h4500_0000;
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wr1 w_ready", w_ready_o, 1);
    checkOutput("wr1 aw_ready", aw_ready_o, 0);
    checkOutput("wr1 err_count", err_count_o, 1);
    checkOutput("wr1 err_addr", err_addr_o, 64'h4500_0000);
    applyStimulus(0, 1, 1, 0, 0, 0);
    tick();
    checkOutput("wr1 b_valid", b_valid_o, 1);
    checkOutput("wr1 b_id", b_id_o, 5);
    checkOutput("wr1 b_resp", b_resp_o, 2'b11);
    checkOutput("wr1 w_ready after last", w_ready_o, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("wr1 b_valid after hs", b_valid_o, 0);
    checkOutput("wr1 aw_ready after hs", aw_ready_o, 1);

    // W before AW stalls
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("early W w_ready", w_ready_o, 0);
    checkOutput("early W b_valid", b_valid_o, 0);

    // 4-beat write, W valid toggling, B held off for 3 cycles
    aw_id_i = 5'd9;
    aw_addr_i = 64'h100;
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, (i % 2) == 0, i == 6, 0, 0, 0);
      tick();
      if (i < 6) checkOutput($sformatf("wr4 b_valid early %0d", i), b_valid_o, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wr4 b_valid hold %0d", i), b_valid_o, 1);
      checkOutput($sformatf("wr4 b_id hold %0d", i), b_id_o, 9);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("wr4 aw_ready after B", aw_ready_o, 1);
    checkOutput("wr4 err_count", err_count_o, 2);
    checkOutput("wr4 err_addr", err_addr_o, 64'h100);

    // read len=7, random r_ready
    ar_id_i = 5'd3;
    ar_addr_i = 64'h3000;
    ar_len_i = 8'd7;
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("rd8 first beat valid", r_valid_o, 1);
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 200) begin
      applyStimulus(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      if (r_valid_o && r_ready_i) begin
        checkOutput($sformatf("rd8 r_last beat %0d", beats), r_last_o, beats == 7);
        checkOutput($sformatf("rd8 r_data beat %0d", beats), r_data_o, RESP_DATA);
        checkOutput($sformatf("rd8 r_id beat %0d", beats), r_id_o, 3);
        checkOutput($sformatf("rd8 r_resp beat %0d", beats), r_resp_o, 2'b11);
        beats++;
      end
      tick();
      cyc++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rd8 beat count", beats, 8);
    checkOutput("rd8 r_valid after", r_valid_o, 0);
    checkOutput("rd8 ar_ready after", ar_ready_o, 1);
    checkOutput("rd8 err_count", err_count_o, 3);
    checkOutput("rd8 err_addr", err_addr_o, 64'h3000);

    // read len=255 with r_ready held high
    ar_id_i = 5'd17;
    ar_len_i = 8'd255;
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    beats = 0;
    last_count = 0;
    last_beat = -1;
    gaps = 0;
    for (int i = 0; i < 256; i++) begin
      if (r_valid_o) begin
        if (r_last_o) begin
          last_count++;
          last_beat = beats;
        end
        beats++;
      end else begin
        gaps++;
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rd256 beats", beats, 256);
    checkOutput("rd256 gaps", gaps, 0);
    checkOutput("rd256 last count", last_count, 1);
    checkOutput("rd256 last position", last_beat, 255);
    checkOutput("rd256 r_valid after", r_valid_o, 0);
    checkOutput("rd256 ar_ready after", ar_ready_o, 1);

    // simultaneous AW and AR
    aw_id_i = 5'd2;
    aw_addr_i = 64'h1000;
    ar_id_i = 5'd4;
    ar_addr_i = 64'h2000;
    ar_len_i = 8'd0;
    applyStimulus(1, 0, 0, 0, 1, 0);
    tick();
    checkOutput("both err_count", err_count_o, 6);
    checkOutput("both err_addr", err_addr_o, 64'h1000);
    checkOutput("both w_ready", w_ready_o, 1);
    checkOutput("both r_valid", r_valid_o, 1);
    checkOutput("both r_last", r_last_o, 1);
    checkOutput("both r_id", r_id_o, 4);
    applyStimulus(0, 1, 1, 0, 0, 1);
    tick();
    checkOutput("both b_valid", b_valid_o, 1);
    checkOutput("both b_id", b_id_o, 2);
    checkOutput("both r_valid after", r_valid_o, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("both aw_ready after", aw_ready_o, 1);

    // saturation: preload counter near the top, then a double increment
    force dut.err_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.err_count_q;
    checkOutput("sat preload", err_count_o, 32'hFFFF_FFFE);
    applyStimulus(1, 0, 0, 0, 1, 0);
    tick();
    checkOutput("sat err_count", err_count_o, 32'hFFFF_FFFF);
    checkOutput("sat err_addr", err_addr_o, 64'h1000);
    applyStimulus(0, 1, 1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0);
    tick();
    checkOutput("sat hold", err_count_o, 32'hFFFF_FFFF);
    checkOutput("sat ar err_addr", err_addr_o, 64'h2000);
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);

    // reset in the middle of a len=7 burst, at beat 3
    ar_id_i = 5'd6;
    ar_len_i = 8'd7;
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    tick();
    checkOutput("mid r_valid before rst", r_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid rst r_valid", r_valid_o, 0);
    checkOutput("mid rst ar_ready", ar_ready_o, 1);
    checkOutput("mid rst r_last", r_last_o, 0);
    checkOutput("mid rst err_count", err_count_o, 0);
    checkOutput("mid rst r_id", r_id_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b1;
    tick();
    ar_id_i = 5'd7;
    ar_len_i = 8'd1;
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("post rst beat0 valid", r_valid_o, 1);
    checkOutput("post rst beat0 id", r_id_o, 7);
    checkOutput("post rst beat0 last", r_last_o, 0);
    tick();
    checkOutput("post rst beat1 last", r_last_o, 1);
    tick();
    checkOutput("post rst done", r_valid_o, 0);
    checkOutput("post rst err_count", err_count_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
